// File: rtl/layer_engine_output_stage_if.sv
// Stream/control bundle between the output stage and its neighbours.
// Valid/ready: a transfer happens on a rising edge where valid & ready are both high; the source holds its payload stable while valid is high and ready is low.
interface layer_engine_output_stage_if #(
    parameter int C_DATA_WIDTH   = 128,
    parameter int C_OPCODE_WIDTH = 64
);
    logic [C_OPCODE_WIDTH-1:0] opcode;
    logic                      opcode_valid;
    logic                      opcode_accept;
    logic [C_DATA_WIDTH-1:0]   datain;
    logic                      datain_valid;
    logic                      datain_ready;
    logic [C_DATA_WIDTH-1:0]   dataout;
    logic                      dataout_valid;
    logic                      dataout_ready;
    logic                      dataout_last;
    logic                      job_done;

    modport master (
        output opcode,
        output opcode_valid,
        input  opcode_accept,
        output datain,
        output datain_valid,
        input  datain_ready,
        input  dataout,
        input  dataout_valid,
        output dataout_ready,
        input  dataout_last,
        input  job_done
    );

    modport slave (
        input  opcode,
        input  opcode_valid,
        output opcode_accept,
        input  datain,
        input  datain_valid,
        output datain_ready,
        output dataout,
        output dataout_valid,
        input  dataout_ready,
        output dataout_last,
        output job_done
    );
endinterface

// File: rtl/layer_engine_output_stage.sv
// Post-processes layer_engine_adder beats (per-lane arithmetic shift, optional ReLU)
// and forwards them in bursts, pulsing job_done once the final beat has left.
module layer_engine_output_stage #(
    parameter int C_DATA_WIDTH   = 128,
    parameter int C_LANE_WIDTH   = 16,
    parameter int C_OPCODE_WIDTH = 64,
    parameter int C_BURST_LEN    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    layer_engine_output_stage_if.slave   bus,
    output logic [1:0]                   state_dbg
);

    localparam int LANES = C_DATA_WIDTH / C_LANE_WIDTH;
    localparam int BW    = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(C_BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]             in_cnt;
    logic [31:0]             out_cnt;
    logic [3:0]              shift_q;
    logic                    relu_q;
    logic [BW-1:0]           burst_cnt;
    logic [C_DATA_WIDTH-1:0] dout_q;
    logic                    valid_q;

    logic                    opcode_take;
    logic                    in_ready;
    logic                    in_hs;
    logic                    out_hs;
    logic                    last_beat;
    logic [C_DATA_WIDTH-1:0] proc_beat;

    logic signed [C_LANE_WIDTH-1:0] lane_s;
    logic signed [C_LANE_WIDTH-1:0] shr_s;

    logic unused_opcode_bits;
    assign unused_opcode_bits = ^bus.opcode[C_OPCODE_WIDTH-1:37];

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        opcode_take = (state == IDLE) & bus.opcode_valid;
        // Input is only taken while beats remain and the output slot is free or draining.
        in_ready    = (state == RUN) & (in_cnt != 32'd0) & (!valid_q | bus.dataout_ready);
        in_hs       = bus.datain_valid & in_ready;
        out_hs      = valid_q & bus.dataout_ready;
        last_beat   = valid_q & ((burst_cnt == BURST_MAX) | (out_cnt == 32'd1));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (opcode_take) begin
                    state_nxt = (bus.opcode[31:0] == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_hs && (out_cnt == 32'd1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job parameters and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt    <= 32'd0;
            out_cnt   <= 32'd0;
            shift_q   <= 4'd0;
            relu_q    <= 1'b0;
            burst_cnt <= '0;
        end else if (opcode_take) begin
            in_cnt    <= bus.opcode[31:0];
            out_cnt   <= bus.opcode[31:0];
            shift_q   <= bus.opcode[35:32];
            relu_q    <= bus.opcode[36];
            burst_cnt <= '0;
        end else begin
            if (in_hs) begin
                in_cnt <= in_cnt - 32'd1;
            end
            if (out_hs) begin
                out_cnt <= out_cnt - 32'd1;
                // A short final burst also restarts the burst count.
                burst_cnt <= last_beat ? '0 : burst_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        proc_beat = '0;
        lane_s    = '0;
        shr_s     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_s = bus.datain[i*C_LANE_WIDTH +: C_LANE_WIDTH];
            shr_s  = lane_s >>> shift_q;
            if (relu_q && shr_s[C_LANE_WIDTH-1]) begin
                proc_beat[i*C_LANE_WIDTH +: C_LANE_WIDTH] = '0;
            end else begin
                proc_beat[i*C_LANE_WIDTH +: C_LANE_WIDTH] = shr_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads on input, empties only when drained with no refill
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_hs) begin
            dout_q  <= proc_beat;
            valid_q <= 1'b1;
        end else if (out_hs) begin
            valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.opcode_accept = opcode_take;
    assign bus.datain_ready  = in_ready;
    assign bus.dataout       = dout_q;
    assign bus.dataout_valid = valid_q;
    assign bus.dataout_last  = last_beat;
    assign bus.job_done      = (state == DONE);
    assign state_dbg         = state;

endmodule

// File: tb/tb_layer_engine_output_stage.sv
// Directed bench for layer_engine_output_stage: scoreboard queue filled by the
// drivers, drained by an output monitor that also checks stalls and job_done.
module tb_layer_engine_output_stage;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_engine_output_stage_if bus ();
  logic [1:0] state_dbg;

  layer_engine_output_stage dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_out = 0;
  int last_hs_cyc = -10;

  // {final_of_job, last, data}
  logic [129:0] exp_q[$];
  int           done_q[$];

  logic rdy_set = 1'b1;
  logic tog_en  = 1'b0;
  logic tog_val = 1'b1;
  assign bus.dataout_ready = tog_en ? tog_val : rdy_set;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (tog_en) tog_val = ~tog_val;
    else tog_val = 1'b1;
  end

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic         prev_stall;
    logic [129:0] prev_out;
    logic [129:0] e;
    int           n;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {bus.dataout_valid, bus.dataout_last, bus.dataout}, prev_out);
        if (bus.dataout_valid && !bus.dataout_ready) begin
          check("stall_in_ready", bus.datain_ready, 1'b0);
          prev_stall = 1'b1;
          prev_out   = {bus.dataout_valid, bus.dataout_last, bus.dataout};
        end else begin
          prev_stall = 1'b0;
        end
        if (bus.dataout_valid && bus.dataout_ready) begin
          beats_out++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected none", bus.dataout);
          end else begin
            e = exp_q.pop_front();
            check("beat", {bus.dataout_last, bus.dataout}, e[128:0]);
            if (e[129]) last_hs_cyc = cyc;
          end
        end
        if (bus.job_done) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_job_done: got 1 expected 0");
          end else begin
            n = done_q.pop_front();
            check("done_drained", exp_q.size(), 0);
            if (n > 0) check("done_latency", cyc - last_hs_cyc, 1);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic start_job(input int n, input logic [3:0] sh, input logic relu);
    logic [63:0] op;
    logic        got;
    op = '0;
    op[63:37] = 27'($urandom());
    op[31:0]  = n;
    op[35:32] = sh;
    op[36]    = relu;
    bus.opcode = op;
    bus.opcode_valid = 1'b1;
    done_q.push_back(n);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.opcode_accept) begin
        got = 1'b1;
        break;
      end
    end
    check("opcode_accept", got, 1'b1);
    @(posedge clk);
    #1;
    bus.opcode_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [127:0] ed,
                           input logic el, input logic fin);
    logic got;
    bus.datain = d;
    bus.datain_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.datain_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL datain_timeout: got ready 0 expected 1");
      bus.datain_valid = 1'b0;
    end else begin
      exp_q.push_back({fin, el, ed});
      @(posedge clk);
      #1;
      bus.datain_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done_q.size() == 0 && exp_q.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got pending %0d expected 0", done_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // stimulus
  initial begin
    logic [127:0] b1, b2, b3, d;
    logic [127:0] v_in, v_s4, v_s4r, v2_in, v2_s15, v3_in, v3_exp;
    int           base;

    bus.opcode = '0;
    bus.opcode_valid = 1'b0;
    bus.datain = '0;
    bus.datain_valid = 1'b0;

    #1 rst = 1'b0;
    #2;
    check("rst_valid", bus.dataout_valid, 1'b0);
    check("rst_last", bus.dataout_last, 1'b0);
    check("rst_done", bus.job_done, 1'b0);
    check("rst_in_ready", bus.datain_ready, 1'b0);
    check("rst_dataout", bus.dataout, 128'h0);
    check("rst_state", state_dbg, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: identity pass, back-to-back
    b1 = rnd_beat(); b2 = rnd_beat(); b3 = rnd_beat();
    start_job(3, 4'd0, 1'b0);
    send_beat(b1, b1, 1'b0, 1'b0);
    check("latency_1cyc", {bus.dataout_valid, bus.dataout}, {1'b1, b1});
    send_beat(b2, b2, 1'b0, 1'b0);
    send_beat(b3, b3, 1'b1, 1'b1);
    wait_idle();

    // 2: lane arithmetic
    v_in   = {16'hFF00, 16'h0100, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0010, 16'h0000};
    v_s4   = {16'hFFF0, 16'h0010, 16'hF800, 16'h07FF, 16'h0123, 16'hFFFF, 16'h0001, 16'h0000};
    v_s4r  = {16'h0000, 16'h0010, 16'h0000, 16'h07FF, 16'h0123, 16'h0000, 16'h0001, 16'h0000};
    v2_in  = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h4000, 16'hC000, 16'h0000, 16'h1234};
    v2_s15 = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    v3_in  = {16'h1234, 16'hFFFE, 16'h0003, 16'h8001, 16'h7FFE, 16'h0000, 16'hFF00, 16'h0100};
    v3_exp = {16'h091A, 16'h0000, 16'h0001, 16'h0000, 16'h3FFF, 16'h0000, 16'h0000, 16'h0080};
    start_job(1, 4'd4, 1'b0);
    send_beat(v_in, v_s4, 1'b1, 1'b1);
    wait_idle();
    start_job(1, 4'd4, 1'b1);
    send_beat(v_in, v_s4r, 1'b1, 1'b1);
    wait_idle();
    start_job(1, 4'd15, 1'b0);
    send_beat(v2_in, v2_s15, 1'b1, 1'b1);
    wait_idle();
    start_job(1, 4'd1, 1'b1);
    send_beat(v3_in, v3_exp, 1'b1, 1'b1);
    wait_idle();

    // 3: 40 beats, bursts of 16, 41st beat held off
    base = beats_out;
    start_job(40, 4'd0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      d = {4{32'(k + 1)}};
      send_beat(d, d, (k == 15 || k == 31 || k == 39), (k == 39));
    end
    bus.datain = rnd_beat();
    bus.datain_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("beat41_held", bus.datain_ready, 1'b0);
    end
    bus.datain_valid = 1'b0;
    wait_idle();
    check("burst_job_count", beats_out - base, 40);

    // 4: toggling downstream ready
    base = beats_out;
    tog_en = 1'b1;
    start_job(10, 4'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      d = rnd_beat();
      send_beat(d, d, (k == 9), (k == 9));
    end
    wait_idle();
    tog_en = 1'b0;
    check("toggle_job_count", beats_out - base, 10);

    // 5: empty job
    start_job(0, 4'd0, 1'b0);
    @(negedge clk);
    check("zero_job_done", bus.job_done, 1'b1);
    check("zero_in_ready", bus.datain_ready, 1'b0);
    check("zero_out_valid", bus.dataout_valid, 1'b0);
    @(negedge clk);
    check("zero_done_once", bus.job_done, 1'b0);
    check("zero_out_valid2", bus.dataout_valid, 1'b0);
    wait_idle();

    // 6: reset mid-job, then a clean 2-beat job
    start_job(20, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      d = rnd_beat();
      send_beat(d, d, 1'b0, 1'b0);
    end
    rst = 1'b0;
    bus.datain_valid = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    check("midrst_valid", bus.dataout_valid, 1'b0);
    check("midrst_last", bus.dataout_last, 1'b0);
    check("midrst_dataout", bus.dataout, 128'h0);
    check("midrst_in_ready", bus.datain_ready, 1'b0);
    check("midrst_done", bus.job_done, 1'b0);
    check("midrst_state", state_dbg, 2'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    b1 = rnd_beat(); b2 = rnd_beat();
    start_job(2, 4'd0, 1'b0);
    send_beat(b1, b1, 1'b0, 1'b0);
    send_beat(b2, b2, 1'b1, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
